// File: rtl/booth_divider_if.sv
// booth_divider_if: load/operand/result bundle for booth_divider; dbz exists only with DIV_ZERO_DETECT_EN.
interface booth_divider_if #(parameter int N = 8);
  logic load;
  logic signed [N-1:0] A;
  logic signed [N-1:0] B;
  logic signed [N-1:0] quot;
  logic signed [N-1:0] rem;
  logic busy;
  logic done;
`ifdef DIV_ZERO_DETECT_EN
  logic dbz;
  modport master (output load, A, B, input quot, rem, busy, done, dbz);
  modport slave (input load, A, B, output quot, rem, busy, done, dbz);
`else
  modport master (output load, A, B, input quot, rem, busy, done);
  modport slave (input load, A, B, output quot, rem, busy, done);
`endif
endinterface

// File: rtl/booth_divider.sv
// booth_divider: signed N-bit sequential restoring divider (N iterations + sign fix).
// DIV_ZERO_DETECT_EN adds the dbz flag and a one-edge exit for B = 0.
module booth_divider #(parameter int N = 8) (
  input logic clk,
  input logic rst,
  booth_divider_if.slave bus
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0] part_q, quo_q, dvs_q, quot_q, rem_q;
  logic neg_q, sa_q, busy_q, done_q;
  logic [N:0] shift_d;
  logic [N-1:0] part_d, mag_a_d, mag_b_d;
  logic take_d;
  always_comb begin
    shift_d = {part_q, quo_q[N-1]};
    take_d = shift_d >= {1'b0, dvs_q};
    part_d = take_d ? N'(shift_d - {1'b0, dvs_q}) : shift_d[N-1:0];
    mag_a_d = bus.A[N-1] ? -bus.A : bus.A;
    mag_b_d = bus.B[N-1] ? -bus.B : bus.B;
  end
`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q;
  assign bus.dbz = dbz_q;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      part_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      quot_q <= '0;
      rem_q <= '0;
      neg_q <= 1'b0;
      sa_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: if (bus.load) begin
          done_q <= 1'b0;
          busy_q <= 1'b1;
          cnt_q <= '0;
          part_q <= '0;
          quo_q <= mag_a_d;
          dvs_q <= mag_b_d;
          neg_q <= bus.A[N-1] ^ bus.B[N-1];
          sa_q <= bus.A[N-1];
          state_q <= CALC;
`ifdef DIV_ZERO_DETECT_EN
          dbz_q <= bus.B == '0;
          if (bus.B == '0) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            quot_q <= '1;
            rem_q <= bus.A;
            state_q <= DONE;
          end
`endif
        end
        CALC: begin
          part_q <= part_d;
          quo_q <= {quo_q[N-2:0], take_d};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_q <= FIX;
        end
        FIX: begin
          // -2^(N-1) / -1 yields magnitude 2^(N-1), which wraps back to -2^(N-1)
          quot_q <= neg_q ? -quo_q : quo_q;
          rem_q <= sa_q ? -part_q : part_q;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.quot = quot_q;
  assign bus.rem = rem_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_booth_divider.sv
// tb_booth_divider: directed table-driven bench for booth_divider (N = 8).
module tb_booth_divider;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int lat, busy_n;
  booth_divider_if #(.N(N)) bus();
  booth_divider #(.N(N)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {int a; int b; int q; int r;} vec_t;
  vec_t vecs[10];
  task automatic chk(input string nm, input integer act, input integer exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic wait_done();
    lat = 0;
    busy_n = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic start(input int a, input int b);
    @(negedge clk);
    bus.A = 8'(a);
    bus.B = 8'(b);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  task automatic check_result(input string nm, input int q, input int r);
    chk({nm, " latency"}, lat, N + 1);
    chk({nm, " busy_cycles"}, busy_n, N + 1);
    chk({nm, " busy_low"}, bus.busy, 0);
    chk({nm, " quot"}, bus.quot, q);
    chk({nm, " rem"}, bus.rem, r);
  endtask
  initial begin
    vecs[0] = '{-75, 7, -10, -5};
    vecs[1] = '{-128, -1, -128, 0};
    vecs[2] = '{-128, 3, -42, -2};
    vecs[3] = '{100, 9, 11, 1};
    vecs[4] = '{127, -127, -1, 0};
    vecs[5] = '{7, -2, -3, 1};
    vecs[6] = '{-7, 2, -3, -1};
    vecs[7] = '{0, 5, 0, 0};
    vecs[8] = '{5, 7, 0, 5};
    vecs[9] = '{127, 1, 127, 0};
    bus.load = 1'b0;
    bus.A = '0;
    bus.B = '0;
    #12;
    chk("reset quot", bus.quot, 0);
    chk("reset rem", bus.rem, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start(vecs[i].a, vecs[i].b);
      wait_done();
      check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r);
    end
    @(negedge clk);
    bus.A = 8'(127);
    bus.B = 8'(-127);
    bus.load = 1'b1;
    @(negedge clk);
    wait_done();
    check_result("b2b first", -1, 0);
    bus.A = 8'(-127);
    bus.B = 8'(-127);
    @(negedge clk);
    chk("b2b restart done_low", bus.done, 0);
    wait_done();
    check_result("b2b second", 1, 0);
    bus.load = 1'b0;
    start(-75, 7);
    repeat (3) @(negedge clk);
    bus.A = 8'(50);
    bus.B = 8'(3);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    wait_done();
    chk("ignored load latency", lat, N - 3);
    chk("ignored load quot", bus.quot, -10);
    chk("ignored load rem", bus.rem, -5);
    start(-75, 7);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst quot", bus.quot, 0);
    chk("midrst rem", bus.rem, 0);
    chk("midrst busy", bus.busy, 0);
    chk("midrst done", bus.done, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("post rst done", bus.done, 0);
    chk("post rst busy", bus.busy, 0);
    start(100, 9);
    wait_done();
    check_result("after rst", 11, 1);
`ifdef DIV_ZERO_DETECT_EN
    start(100, 0);
    chk("dbz done", bus.done, 1);
    chk("dbz busy", bus.busy, 0);
    chk("dbz flag", bus.dbz, 1);
    chk("dbz quot", bus.quot, -1);
    chk("dbz rem", bus.rem, 100);
    start(100, 9);
    chk("dbz cleared", bus.dbz, 0);
    wait_done();
    check_result("after dbz", 11, 1);
`else
    start(100, 0);
    wait_done();
    chk("b0 latency", lat, N + 1);
    chk("b0 busy_cycles", busy_n, N + 1);
`endif
    chk("busy_and_done", bus.busy & bus.done, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/booth_divider.md
BOOTH_DIVIDER -- requirements
Module: booth_divider

Interface
REQ-001 Parameter: N, 8, operand width in bits (N >= 2).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed clock and reset first:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- load  input  1  start request, sampled on rising clk
- A  input  N  signed dividend
- B  input  N  signed divisor
- quot  output  N  signed quotient
- rem  output  N  signed remainder
- busy  output  1  division in progress
- done  output  1  result valid
- dbz  output  1  divide-by-zero flag (present only with DIV_ZERO_DETECT_EN)

Function
REQ-003 The block SHALL implement signed sequential division as the inverse of the team's sequential Booth multiplier, using the same load/operand convention.
REQ-004 The block SHALL have states IDLE, CALC, FIX and DONE.
REQ-005 The block SHALL accept load only in IDLE or DONE; on that edge it SHALL capture A and B, clear done, set busy, load the magnitudes |A| and |B|, set the iteration counter to 0, and enter CALC.
REQ-006 load in CALC or FIX SHALL be ignored; operand changes after capture SHALL NOT affect the result.
REQ-007 CALC SHALL perform one restoring shift-subtract iteration per cycle on the N-bit magnitudes for exactly N cycles, then enter FIX.
REQ-008 FIX SHALL apply signs in one cycle, then enter DONE:
- quotient negative iff sign(A) != sign(B); truncation toward zero
- rem carries the sign of A; A = quot*B + rem with |rem| < |B|
REQ-009 done SHALL rise on the edge leaving FIX (latency N+1 edges after the load edge, N+2 cycles total), and done, quot and rem SHALL hold until the next accepted load or reset.
REQ-010 busy SHALL be 1 exactly in CALC and FIX; busy and done SHALL never both be 1.
REQ-011 Overflow case (-2^(N-1)) / (-1) SHALL give quot = -2^(N-1) (two's-complement wrap) and rem = 0, with no flag.
REQ-012 A load held high across DONE SHALL restart on every DONE entry (back-to-back operation).
REQ-013 The magnitude of -2^(N-1) SHALL be handled as an N-bit unsigned value, so no extra input bit is required.

Reset
REQ-014 rst low SHALL immediately force IDLE and set quot = 0, rem = 0, busy = 0, done = 0, counter = 0, and dbz = 0 (when present), regardless of the clock.
REQ-015 Reset asserted mid-operation SHALL abort the operation; no done pulse follows reset release.
REQ-016 The first load SHALL be honoured on the first rising edge after rst goes high.

Configuration
REQ-017 The macro DIV_ZERO_DETECT_EN SHALL control divide-by-zero detection.
REQ-018 With DIV_ZERO_DETECT_EN defined, the dbz port SHALL exist, and B = 0 at load SHALL:
- skip CALC and FIX and enter DONE on the next edge
- set dbz = 1, quot = all ones, rem = A
- clear dbz on the next accepted load
REQ-019 Without DIV_ZERO_DETECT_EN, the dbz port SHALL be absent, B = 0 SHALL follow normal N+1-edge timing, and quot and rem SHALL be unspecified.

Verification
REQ-020 The bench SHALL cover these directed scenarios (N = 8):
- A = -75, B = 7, load for one cycle -> busy for 9 cycles, then done = 1, quot = -10, rem = -5.
- A = 127, B = -127, then A = -127, B = -127 loaded back-to-back on DONE -> quot = -1, rem = 0, then quot = 1, rem = 0, each with exact latency.
- A = -128, B = -1 -> quot = -128, rem = 0; A = -128, B = 3 -> quot = -42, rem = -2.
- load pulsed during CALC with different operands -> ignored; first result is unchanged.
- rst low at CALC cycle 4 -> all outputs 0 immediately; after release, a load of A = 100, B = 9 -> quot = 11, rem = 1.
- With DIV_ZERO_DETECT_EN, A = 100, B = 0 -> done after 1 edge, dbz = 1, quot = -1, rem = 100; a following valid load clears dbz.
